// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter with a FIFO in front and an 8-character ASCII display window.
// Define UART_DISPLAY_EN to build the scrolling display; otherwise uart_display_data is constant spaces.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          Clk_CPU,
    input  logic                          rst,
    input  logic                          uart_we,
    input  logic [7:0]                    data_in,
    output logic                          uart_ready,
    output logic                          uart_tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic [63:0]                   uart_display_data
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int BW  = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [63:0]   SPACES    = 64'h2020202020202020;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    state_t        r_state;
    logic          r_tx;
    logic          r_busy;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;

    logic          w_ready;
    logic          w_push;
    logic          w_pop;
    logic          w_baud_done;

    // Readiness comes from the registered count only, so a full FIFO refuses a write even in its pop cycle.
    assign w_ready     = (r_count < DEPTH_C);
    assign w_push      = uart_we && w_ready;
    assign w_pop       = (r_state == S_IDLE) && (r_count != {CW{1'b0}});
    assign w_baud_done = (r_baud == BAUD_LAST);

    assign uart_ready = w_ready;
    assign uart_tx    = r_tx;
    assign tx_busy    = r_busy;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge Clk_CPU) begin
        if (w_push) begin
            r_mem[r_wptr] <= data_in;
        end
    end

    // Pointers, occupancy and the sticky drop flag.
    always_ff @(posedge Clk_CPU or posedge rst) begin
        if (rst) begin
            r_wptr     <= {AW{1'b0}};
            r_rptr     <= {AW{1'b0}};
            r_count    <= {CW{1'b0}};
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (uart_we && !w_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // 8N1 serializer; the line level is registered and set on each state transition.
    always_ff @(posedge Clk_CPU or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_baud    <= {BW{1'b0}};
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift <= r_mem[r_rptr];
                        r_state <= S_START;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_baud  <= {BW{1'b0}};
                    end
                end
                S_START: begin
                    if (w_baud_done) begin
                        r_state   <= S_DATA;
                        r_tx      <= r_shift[0];
                        r_baud    <= {BW{1'b0}};
                        r_bit_idx <= 3'd0;
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                S_DATA: begin
                    if (w_baud_done) begin
                        r_baud <= {BW{1'b0}};
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                S_STOP: begin
                    if (w_baud_done) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_baud  <= {BW{1'b0}};
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_baud  <= {BW{1'b0}};
                end
            endcase
        end
    end

`ifdef UART_DISPLAY_EN
    logic [63:0] r_disp;

    // Scrolling window of accepted bytes; a form feed blanks it while still being transmitted.
    always_ff @(posedge Clk_CPU or posedge rst) begin
        if (rst) begin
            r_disp <= SPACES;
        end else if (w_push) begin
            if (data_in == 8'h0C) begin
                r_disp <= SPACES;
            end else begin
                r_disp <= {r_disp[55:0], data_in};
            end
        end
    end

    assign uart_display_data = r_disp;
`else
    assign uart_display_data = SPACES;
`endif

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered byte-output channel on the Clk_CPU domain, sitting directly downstream of MIO_BUS's UART write port. It accepts bytes from the CPU's memory-mapped UART store, queues them in a small FIFO, and serializes them as 8N1 frames on a TX pin. It also maintains a scrolling 8-character ASCII window that MULTI_CH32 shows on the 7-segment display. `uart_ready` is the backpressure flag the CPU polls through MIO_BUS.

## Interface
- CLKS_PER_BIT, 16, Clk_CPU cycles per serial bit; legal range 2..65535.
- FIFO_DEPTH, 8, FIFO entries; power of two, minimum 2.
- Clk_CPU  input  1  CPU clock; all state is updated on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- uart_we  input  1  write strobe from MIO_BUS; held for exactly one cycle per store.
- data_in  input  8  byte to enqueue.
- uart_ready  output  1  high when the FIFO can accept a byte (count < FIFO_DEPTH).
- uart_tx  output  1  serial line, idle high.
- tx_busy  output  1  high while the FSM is not in IDLE.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  number of occupied entries.
- overflow  output  1  sticky flag; set when a write is dropped.
- uart_display_data  output  64  last 8 accepted bytes; newest byte in [7:0], oldest in [63:56].

## Operation
- Reset values:
  - uart_tx=1, tx_busy=0, fifo_count=0, uart_ready=1, overflow=0.
  - uart_display_data=64'h2020202020202020 (eight ASCII spaces).
  - FSM=IDLE; read and write pointers = 0.
- Push:
  - When uart_we && uart_ready, data_in is written at wptr and wptr increments, wrapping modulo FIFO_DEPTH.
  - When uart_we && !uart_ready, the byte is discarded and overflow is set to 1. Overflow clears only on rst.
- Pop:
  - In IDLE with count>0, the entry at rptr is loaded into the 8-bit shift register, rptr increments (wrapping), and the FSM moves to START.
- Simultaneous push and pop: count is unchanged.
- Full and popping in the same cycle: uart_ready is still 0 from the registered count, so the write is refused.
- FSM states (8N1, LSB first):
  - IDLE: uart_tx=1.
  - START: uart_tx=0 for CLKS_PER_BIT cycles.
  - DATA: uart_tx=shift[0] for CLKS_PER_BIT cycles per bit. Shift right after each bit; 8 bits counted by a 3-bit index.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles, then return to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and is cleared on every state entry.
- Display window:
  - On each accepted push, uart_display_data <= {uart_display_data[55:0], data_in}.
  - Exception: data_in==8'h0C (form feed) reloads all eight spaces, and the byte is still enqueued for TX.
  - Dropped bytes never touch the display.
- Reset mid-frame: everything returns to reset values at once. uart_tx goes high asynchronously, and the partial frame and queued bytes are lost.

## Timing
- All outputs are registered except uart_ready, which is combinational from the registered count.
- Write accepted on edge N → fifo_count and the display update at N+1.
- With the FIFO empty and IDLE: pop occurs on edge N+1, START is entered, and uart_tx falls after edge N+1. tx_busy rises on the same edge.
- Frame length: exactly 10*CLKS_PER_BIT cycles from START entry to IDLE entry.
- Back-to-back queued bytes: one IDLE cycle (uart_tx=1) separates the end of STOP from the next START, giving a period of 10*CLKS_PER_BIT+1 cycles.
- A full FIFO frees one slot at the pop edge; uart_ready rises in the cycle after that edge.

## Configuration
- UART_DISPLAY_EN defined:
  - The display shift window and form-feed clear are implemented as described.
- UART_DISPLAY_EN undefined:
  - uart_display_data is constant 64'h2020202020202020 and no display registers are synthesized.
  - FIFO, TX and overflow behaviour are identical to the defined case.

## Test plan
- Run all scenarios with CLKS_PER_BIT=4 and FIFO_DEPTH=8.
- Reset, then a single write of 8'h41 → uart_tx low 2 edges after the write. Then, 4 cycles per bit, the line carries 1,0,0,0,0,0,1,0 followed by stop=1. tx_busy is high for 40 cycles; uart_display_data=64'h2020202020202041.
- 10 consecutive writes (8'h30..8'h39) while the first frame is sending → first 9 accepted (one popped immediately, 8 queued), 10th dropped. overflow=1, fifo_count=8, uart_ready=0; display=64'h3132333435363738 (the 10th byte 0x39 is not shown).
- Drain after the previous scenario → 9 frames emitted in order 0x30..0x38, each 41-cycle period apart; fifo_count returns to 0; tx_busy falls after the last STOP.
- Write 8'h48, 8'h49, then 8'h0C → display=64'h2020202020202020 after the third write, and three frames (0x48, 0x49, 0x0C) are transmitted.
- Assert rst during DATA bit 3 of a frame with 3 bytes queued → uart_tx=1 immediately; fifo_count=0, overflow=0, display reset to spaces. No further frames until a new write.
- Wrap-around: push/pop 20 bytes one at a time → pointers wrap and the bytes are transmitted in order with no corruption.
